// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: picks one DRAM command requester per gclk.clk cycle.
//
// Ports:
//   gclk         clock bundle; only gclk.clk is used, all state on its rising edge
//   rst          asynchronous reset, active low
//   port_req     per-port level request (requester cmd FIFO non-empty)
//   port_we      per-port head-of-FIFO is a write, valid with port_req
//   af_full      controller address FIFO full, blocks new grants
//   wb_full      controller write buffer full, blocks new grants
//   credit_ret   one return-info FIFO entry popped this cycle
//   grant        registered one-hot grant, one cycle wide
//   grant_valid  OR of grant
//   grant_id     index of the granted port, valid with grant_valid
//   grant_we     granted request is a write, valid with grant_valid
//   credits      free return-info FIFO entries
//   credit_err   sticky, set by a credit return while all credits are free
//
// Arbitration is round-robin starting at ptr. A freshly granted port is
// masked for REQ_LAT cycles because its cmdfifo_empty view lags the pop.
// A write grant is followed by WR_BUBBLE idle cycles, since write data takes
// two clk2x beats per entry.

package iu_clk_pkg;
  typedef struct packed {
    logic clk;
    logic clk2x;
  } iu_clk_type;
endpackage

module mem_req_scheduler
  import iu_clk_pkg::*;
#(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned CREDITS   = 16,
  parameter int unsigned REQ_LAT   = 2,
  parameter int unsigned WR_BUBBLE = 1,
  localparam int unsigned IW       = (NPORT > 1) ? $clog2(NPORT) : 1,
  localparam int unsigned CW       = $clog2(CREDITS + 1)
) (
  input  iu_clk_type       gclk,
  input  logic             rst,
  input  logic [NPORT-1:0] port_req,
  input  logic [NPORT-1:0] port_we,
  input  logic             af_full,
  input  logic             wb_full,
  input  logic             credit_ret,
  output logic [NPORT-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_id,
  output logic             grant_we,
  output logic [CW-1:0]    credits,
  output logic             credit_err
);

  localparam int unsigned MW = (REQ_LAT > 0) ? $clog2(REQ_LAT + 1) : 1;
  localparam int unsigned BW = (WR_BUBBLE > 0) ? $clog2(WR_BUBBLE + 1) : 1;

  typedef enum logic [0:0] {StArb, StBubble} state_e;

  logic clk;
  assign clk = gclk.clk;

  logic unused_clk2x;
  assign unused_clk2x = gclk.clk2x;

  state_e           state_q;
  logic [BW-1:0]    bub_cnt_q;
  logic [IW-1:0]    ptr_q;
  logic [MW-1:0]    mask_cnt_q [NPORT];
  // Low for the first edge after reset release so no grant lands on it.
  logic             run_q;

  logic [NPORT-1:0] eligible;
  logic             en;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [IW-1:0]    cand;
  logic [NPORT-1:0] sel_onehot;
  logic             issue;

  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      eligible[i] = port_req[i] & (mask_cnt_q[i] == '0);
    end
  end

  assign en = run_q & ~af_full & ~wb_full & (credits != '0) & (state_q == StArb);

  // Rotating priority scan from ptr; index arithmetic wraps since NPORT is 2^n.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      cand = ptr_q + IW'(k);
      if (!sel_valid && eligible[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  assign issue = en & sel_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StArb;
      bub_cnt_q   <= '0;
      ptr_q       <= '0;
      run_q       <= 1'b0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      grant_we    <= 1'b0;
      credits     <= CW'(CREDITS);
      credit_err  <= 1'b0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        mask_cnt_q[i] <= '0;
      end
    end else begin
      run_q       <= 1'b1;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_we    <= 1'b0;

      if (issue) begin
        grant       <= sel_onehot;
        grant_valid <= 1'b1;
        grant_id    <= sel_idx;
        grant_we    <= port_we[sel_idx];
        ptr_q       <= sel_idx + IW'(1);
      end

      for (int unsigned i = 0; i < NPORT; i++) begin
        if (issue && (sel_idx == IW'(i))) begin
          mask_cnt_q[i] <= MW'(REQ_LAT);
        end else if (mask_cnt_q[i] != '0) begin
          mask_cnt_q[i] <= mask_cnt_q[i] - MW'(1);
        end
      end

      unique case (state_q)
        StArb: begin
          if (issue && port_we[sel_idx] && (WR_BUBBLE > 0)) begin
            state_q   <= StBubble;
            bub_cnt_q <= BW'(WR_BUBBLE);
          end
        end
        StBubble: begin
          if (bub_cnt_q <= BW'(1)) begin
            state_q <= StArb;
          end else begin
            bub_cnt_q <= bub_cnt_q - BW'(1);
          end
        end
        default: state_q <= StArb;
      endcase

      // A grant and a return in the same cycle cancel out.
      if (issue && !credit_ret) begin
        credits <= credits - CW'(1);
      end else if (credit_ret && !issue) begin
        if (credits == CW'(CREDITS)) begin
          credit_err <= 1'b1;
        end else begin
          credits <= credits + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_req_scheduler.sv
module tb_mem_req_scheduler;
  import iu_clk_pkg::*;

  logic clk = 1'b0;
  logic clk2x = 1'b0;
  always #4 clk = ~clk;
  always #2 clk2x = ~clk2x;

  iu_clk_type gclk;
  assign gclk = {clk, clk2x};

  logic rst;

  // Instance A: 2 ports, REQ_LAT=0, WR_BUBBLE=1
  logic [1:0] a_req, a_we;
  logic       a_af, a_wb, a_cr;
  logic [1:0] a_grant;
  logic       a_gv, a_gwe, a_cerr;
  logic [0:0] a_gid;
  logic [4:0] a_credits;

  // Instance B: 4 ports, REQ_LAT=2
  logic [3:0] b_req, b_we;
  logic       b_af, b_wb, b_cr;
  logic [3:0] b_grant;
  logic       b_gv, b_gwe, b_cerr;
  logic [1:0] b_gid;
  logic [4:0] b_credits;

  mem_req_scheduler #(
    .NPORT(2), .CREDITS(16), .REQ_LAT(0), .WR_BUBBLE(1)
  ) u_dut_a (
    .gclk(gclk), .rst(rst), .port_req(a_req), .port_we(a_we),
    .af_full(a_af), .wb_full(a_wb), .credit_ret(a_cr),
    .grant(a_grant), .grant_valid(a_gv), .grant_id(a_gid), .grant_we(a_gwe),
    .credits(a_credits), .credit_err(a_cerr)
  );

  mem_req_scheduler #(
    .NPORT(4), .CREDITS(16), .REQ_LAT(2), .WR_BUBBLE(1)
  ) u_dut_b (
    .gclk(gclk), .rst(rst), .port_req(b_req), .port_we(b_we),
    .af_full(b_af), .wb_full(b_wb), .credit_ret(b_cr),
    .grant(b_grant), .grant_valid(b_gv), .grant_id(b_gid), .grant_we(b_gwe),
    .credits(b_credits), .credit_err(b_cerr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = '0; a_we = '0; a_af = 1'b0; a_wb = 1'b0; a_cr = 1'b0;
    b_req = '0; b_we = '0; b_af = 1'b0; b_wb = 1'b0; b_cr = 1'b0;
  endtask

  // Leaves both DUTs past their post-release dead edge, ready to grant.
  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_gv", 32'(a_gv), 32'h0);
    chk("rst_gid", 32'(a_gid), 32'h0);
    chk("rst_gwe", 32'(a_gwe), 32'h0);
    chk("rst_credits", 32'(a_credits), 32'd16);
    chk("rst_cerr", 32'(a_cerr), 32'h0);

    // Requests already pending at release: first edge must not grant.
    a_req = 2'b11;
    rst = 1'b1;
    tick();
    chk("first_edge_nogrant", 32'(a_gv), 32'h0);

    // Alternating round-robin, REQ_LAT=0
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 32'(a_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_gid", 32'(a_gid), 32'(k % 2));
      chk("rr_credits", 32'(a_credits), 32'(15 - k));
    end
    a_req = 2'b00;
    tick();
    chk("rr_idle", 32'(a_gv), 32'h0);

    // Single port on 4-port instance, REQ_LAT=2: grant every third cycle
    b_req = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("mask_grant", 32'(b_grant), (k % 3 == 0) ? 32'h4 : 32'h0);
      if (k % 3 == 0) chk("mask_gid", 32'(b_gid), 32'd2);
    end
    b_req = 4'b0000;

    // Write bubble: move ptr to port 1 first with a port-0 read
    a_req = 2'b01;
    tick();
    chk("wb_pre", 32'(a_grant), 32'h1);
    a_req = 2'b11;
    a_we = 2'b10;
    tick();
    chk("wb_wgrant", 32'(a_grant), 32'h2);
    chk("wb_wwe", 32'(a_gwe), 32'h1);
    tick();
    chk("wb_bubble", 32'(a_grant), 32'h0);
    tick();
    chk("wb_after", 32'(a_grant), 32'h1);
    chk("wb_after_we", 32'(a_gwe), 32'h0);
    a_req = 2'b00;
    a_we = 2'b00;
    tick();

    // Credit exhaustion
    do_reset();
    a_req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("cred_gv", 32'(a_gv), 32'h1);
      chk("cred_cnt", 32'(a_credits), 32'(15 - k));
    end
    tick();
    chk("cred_block_gv", 32'(a_gv), 32'h0);
    chk("cred_block_cnt", 32'(a_credits), 32'd0);
    a_cr = 1'b1;
    tick();
    chk("cred_ret_gv", 32'(a_gv), 32'h0);
    chk("cred_ret_cnt", 32'(a_credits), 32'd1);
    a_cr = 1'b0;
    tick();
    chk("cred_one_gv", 32'(a_gv), 32'h1);
    chk("cred_one_cnt", 32'(a_credits), 32'd0);
    tick();
    chk("cred_stop_gv", 32'(a_gv), 32'h0);
    a_req = 2'b00;

    // af_full / wb_full blocking and simultaneous grant+return
    do_reset();
    a_af = 1'b1;
    a_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("af_block", 32'(a_grant), 32'h0);
    end
    a_af = 1'b0;
    tick();
    chk("af_release", 32'(a_grant), 32'h1);
    chk("af_release_cnt", 32'(a_credits), 32'd15);
    a_cr = 1'b1;
    tick();
    chk("simul_grant", 32'(a_grant), 32'h2);
    chk("simul_cnt", 32'(a_credits), 32'd15);
    a_cr = 1'b0;
    a_wb = 1'b1;
    tick();
    chk("wbfull_block", 32'(a_gv), 32'h0);
    chk("wbfull_cnt", 32'(a_credits), 32'd15);
    a_wb = 1'b0;
    a_req = 2'b00;
    tick();

    // Credit overflow error
    do_reset();
    a_cr = 1'b1;
    tick();
    chk("cerr_set", 32'(a_cerr), 32'h1);
    chk("cerr_cnt", 32'(a_credits), 32'd16);
    a_cr = 1'b0;
    tick();
    chk("cerr_sticky", 32'(a_cerr), 32'h1);

    // Asynchronous reset in the middle of a write bubble
    a_req = 2'b10;
    a_we = 2'b10;
    tick();
    chk("mid_wgrant", 32'(a_grant), 32'h2);
    chk("mid_gid", 32'(a_gid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_grant", 32'(a_grant), 32'h0);
    chk("async_gv", 32'(a_gv), 32'h0);
    chk("async_gid", 32'(a_gid), 32'h0);
    chk("async_gwe", 32'(a_gwe), 32'h0);
    chk("async_credits", 32'(a_credits), 32'd16);
    chk("async_cerr", 32'(a_cerr), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_edge1", 32'(a_gv), 32'h0);
    tick();
    chk("post_rst_edge2", 32'(a_grant), 32'h2);
    a_req = 2'b00;
    a_we = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
